tlb_op_ctrl: RTL

Sequencer that executes TLB maintenance instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) against the TLB entry memory on behalf of the CSR/exception stage. It accepts one operation at a time over a valid/ready handshake and drives the memory's read index, write port and clear port. It returns a registered response: hit/index for search, entry for read, error for illegal INVTLB op. TLBSRCH scans entries serially through the single read port, so no extra compare array is needed.

---
 rtl/tlb_op_ctrl.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/tlb_op_ctrl.sv
// TLB maintenance sequencer: runs TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB against the TLB entry
// memory one operation at a time and returns a registered single-cycle response.
module tlb_op_ctrl #(
    parameter int unsigned TLBNUM = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [2:0]                req_op,
    input  logic [$clog2(TLBNUM)-1:0] req_index,
    input  logic [4:0]                req_inv_op,
    input  logic [9:0]                req_asid,
    input  logic [31:0]               req_vaddr,
    input  logic [88:0]               req_entry,
    output logic                      resp_valid,
    output logic                      resp_hit,
    output logic [$clog2(TLBNUM)-1:0] resp_index,
    output logic [88:0]               resp_entry,
    output logic                      resp_err,
    output logic [$clog2(TLBNUM)-1:0] mem_r_index,
    input  logic [88:0]               mem_r_entry,
    output logic                      mem_we,
    output logic [$clog2(TLBNUM)-1:0] mem_w_index,
    output logic [88:0]               mem_w_entry,
    output logic [2:0]                mem_clear,
    output logic [9:0]                mem_clear_asid,
    output logic [31:0]               mem_clear_vaddr
);

    localparam int unsigned IW = $clog2(TLBNUM);

    localparam logic [2:0] OpSrch = 3'd0;
    localparam logic [2:0] OpRd   = 3'd1;
    localparam logic [2:0] OpWr   = 3'd2;
    localparam logic [2:0] OpFill = 3'd3;
    localparam logic [2:0] OpInv  = 3'd4;

    typedef enum logic [1:0] {StIdle, StExec, StScan} state_e;

    state_e          state_q, state_d;
    logic [2:0]      op_q;
    logic [IW-1:0]   idx_q;
    logic [4:0]      inv_op_q;
    logic [9:0]      asid_q;
    logic [31:0]     vaddr_q;
    logic [88:0]     entry_q;
    logic [IW-1:0]   fill_q;
    logic [IW-1:0]   scan_q;

    logic            resp_valid_q;
    logic            resp_hit_q;
    logic [IW-1:0]   resp_index_q;
    logic [88:0]     resp_entry_q;
    logic            resp_err_q;

    logic            accept;
    logic [2:0]      inv_code;
    logic            exec_err;
    logic            vpn_eq;
    logic            scan_hit;
    logic            scan_last;
    logic            scan_done;

    assign accept = (state_q == StIdle) && req_valid;

    // Fields of the entry currently presented on the read port.
    logic [18:0] rd_vpn2;
    logic [9:0]  rd_asid;
    logic [5:0]  rd_ps;
    logic        rd_g;
    logic        rd_e;

    assign rd_vpn2 = mem_r_entry[88:70];
    assign rd_asid = mem_r_entry[69:60];
    assign rd_ps   = mem_r_entry[59:54];
    assign rd_g    = mem_r_entry[53];
    assign rd_e    = mem_r_entry[52];

    // 4MB pages compare only the upper ten VPN2 bits.
    assign vpn_eq    = (rd_ps == 6'd21) ? (rd_vpn2[18:9] == vaddr_q[31:22])
                                        : (rd_vpn2 == vaddr_q[31:13]);
    assign scan_hit  = rd_e && (rd_g || (rd_asid == asid_q)) && vpn_eq;
    assign scan_last = (scan_q == IW'(TLBNUM - 1));
    assign scan_done = scan_hit || scan_last;

    always_comb begin
        if (inv_op_q <= 5'd1) begin
            inv_code = 3'd1;
        end else if (inv_op_q <= 5'd6) begin
            inv_code = inv_op_q[2:0];
        end else begin
            inv_code = 3'd0;
        end
    end

    assign exec_err = (op_q > OpInv) || ((op_q == OpInv) && (inv_code == 3'd0));

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = (req_op == OpSrch) ? StScan : StExec;
                end
            end
            StExec: state_d = StIdle;
            StScan: begin
                if (scan_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic: memory command and request handshake
    always_comb begin
        req_ready       = (state_q == StIdle);
        mem_r_index     = '0;
        mem_we          = 1'b0;
        mem_w_index     = '0;
        mem_w_entry     = '0;
        mem_clear       = 3'd0;
        mem_clear_asid  = '0;
        mem_clear_vaddr = '0;
        unique case (state_q)
            StExec: begin
                case (op_q)
                    OpWr, OpFill: begin
                        mem_we      = 1'b1;
                        mem_w_index = idx_q;
                        mem_w_entry = entry_q;
                    end
                    OpRd: mem_r_index = idx_q;
                    OpInv: begin
                        mem_clear       = inv_code;
                        mem_clear_asid  = asid_q;
                        mem_clear_vaddr = vaddr_q;
                    end
                    default: ;
                endcase
            end
            StScan:  mem_r_index = scan_q;
            default: ;
        endcase
    end

    // Free-running fill counter; the FILL target is captured at accept.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q     <= '0;
            idx_q    <= '0;
            inv_op_q <= '0;
            asid_q   <= '0;
            vaddr_q  <= '0;
            entry_q  <= '0;
        end else if (accept) begin
            op_q     <= req_op;
            idx_q    <= (req_op == OpFill) ? fill_q : req_index;
            inv_op_q <= req_inv_op;
            asid_q   <= req_asid;
            vaddr_q  <= req_vaddr;
            entry_q  <= req_entry;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scan_q <= '0;
        end else if (state_q == StScan) begin
            scan_q <= scan_q + 1'b1;
        end else begin
            scan_q <= '0;
        end
    end

    // Response registers hold their value until the next response.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_index_q <= '0;
            resp_entry_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            if (state_q == StExec) begin
                resp_valid_q <= 1'b1;
                resp_hit_q   <= 1'b0;
                resp_err_q   <= exec_err;
                if ((op_q == OpWr) || (op_q == OpFill)) begin
                    resp_index_q <= idx_q;
                end
                if (op_q == OpRd) begin
                    resp_entry_q <= mem_r_entry;
                end
            end else if ((state_q == StScan) && scan_done) begin
                resp_valid_q <= 1'b1;
                resp_hit_q   <= scan_hit;
                resp_err_q   <= 1'b0;
                resp_index_q <= scan_hit ? scan_q : '0;
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_hit   = resp_hit_q;
    assign resp_index = resp_index_q;
    assign resp_entry = resp_entry_q;
    assign resp_err   = resp_err_q;

endmodule
